// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scan
// Brief   : 4x4 matrix keypad scanner with per-key press/release debounce.
// Rev     : 1.0  initial release
// ============================================================================
module keypad_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   localparam logic [TW-1:0] C_TICK_MAX = TW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] C_DB       = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] C_CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]    r_col_s1;
   logic [3:0]    r_col_s2;
   logic [TW-1:0] r_tick_cnt;
   state_t        r_state;
   logic [1:0]    r_row_idx;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_cap_row;
   logic [1:0]    r_cap_col;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   logic          r_key_held;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic          w_tick;
   logic          w_any_low;
   logic [1:0]    w_low_col;
   logic          w_sel_high;
   logic [CW-1:0] w_cnt_inc;

   state_t        w_state_nxt;
   logic [1:0]    w_row_idx_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    w_cap_row_nxt;
   logic [1:0]    w_cap_col_nxt;
   logic [3:0]    w_key_code_nxt;
   logic          w_key_valid_nxt;
   logic          w_key_held_nxt;

   // Column synchronizer; idle level is all-high (pull-ups).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_s1 <= 4'b1111;
         r_col_s2 <= 4'b1111;
      end else begin
         r_col_s1 <= col;
         r_col_s2 <= r_col_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_tick = (r_tick_cnt == C_TICK_MAX);

   // Lowest-index low column wins when several keys share the active row.
   always_comb begin
      w_any_low = 1'b1;
      w_low_col = 2'd0;
      if (!r_col_s2[0]) begin
         w_low_col = 2'd0;
      end else if (!r_col_s2[1]) begin
         w_low_col = 2'd1;
      end else if (!r_col_s2[2]) begin
         w_low_col = 2'd2;
      end else if (!r_col_s2[3]) begin
         w_low_col = 2'd3;
      end else begin
         w_any_low = 1'b0;
      end
   end

   assign w_sel_high = r_col_s2[r_cap_col];
   assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_row_idx_nxt   = r_row_idx;
      w_cnt_nxt       = r_cnt;
      w_cap_row_nxt   = r_cap_row;
      w_cap_col_nxt   = r_cap_col;
      w_key_code_nxt  = r_key_code;
      w_key_valid_nxt = 1'b0;
      w_key_held_nxt  = r_key_held;

      if (w_tick) begin
         case (r_state)
            ST_SCAN: begin
               if (w_any_low) begin
                  w_cap_row_nxt = r_row_idx;
                  w_cap_col_nxt = w_low_col;
                  w_cnt_nxt     = CW'(1);
                  w_state_nxt   = ST_DEBOUNCE;
               end else begin
                  w_row_idx_nxt = r_row_idx + 2'd1;
               end
            end

            ST_DEBOUNCE: begin
               if (!w_sel_high) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == C_DB) begin
                     w_key_code_nxt  = {r_cap_row, r_cap_col};
                     w_key_valid_nxt = 1'b1;
                     w_key_held_nxt  = 1'b1;
                     w_state_nxt     = ST_HELD;
                  end
               end else begin
                  w_row_idx_nxt = r_cap_row + 2'd1;
                  w_state_nxt   = ST_SCAN;
               end
            end

            ST_HELD: begin
               if (w_sel_high) begin
                  w_cnt_nxt   = CW'(1);
                  w_state_nxt = ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               if (w_sel_high) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == C_DB) begin
                     w_key_held_nxt = 1'b0;
                     w_row_idx_nxt  = r_cap_row + 2'd1;
                     w_state_nxt    = ST_SCAN;
                  end
               end else begin
                  w_state_nxt = ST_HELD;
               end
            end

            default: begin
               w_state_nxt = ST_SCAN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SCAN;
         r_row_idx   <= 2'd0;
         r_cnt       <= '0;
         r_cap_row   <= 2'd0;
         r_cap_col   <= 2'd0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_row_idx   <= w_row_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cap_row   <= w_cap_row_nxt;
         r_cap_col   <= w_cap_col_nxt;
         r_key_code  <= w_key_code_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_key_held  <= w_key_held_nxt;
      end
   end

   // Row drive decoded from a registered index so reset forces row 0 at once.
   assign row       = ~(4'b0001 << r_row_idx);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scan
// Brief   : Self-checking bench for keypad_scan against a key-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 3;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed;

   int n_checks;
   int n_fail;
   int n_valid_seen;

   // Behavioural model state: watched key (-1 while scanning) and run lengths.
   int         m_tick, m_row, m_watch, m_low, m_high, m_code;
   bit         m_held, m_valid;
   logic [3:0] m_s1, m_s2;

   keypad_scan #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_TICKS (DB)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Keypad matrix: a pressed key shorts its column to its driven-low row.
   always_comb begin
      col = 4'b1111;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (pressed[i*4+j] && !row[i]) col[j] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_tick = 0; m_row = 0; m_watch = -1; m_low = 0; m_high = 0;
      m_code = 0; m_held = 0; m_valid = 0; m_s1 = 4'hF; m_s2 = 4'hF;
   endfunction

   function automatic int lowest_low(input logic [3:0] v);
      for (int j = 0; j < 4; j++) if (!v[j]) return j;
      return 0;
   endfunction

   task automatic model_edge(input logic [3:0] c);
      logic [3:0] s;
      logic       cb;
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = c;
      m_valid = 0;
      if (m_tick != SCAN_DIV - 1) begin
         m_tick++;
         return;
      end
      m_tick = 0;
      if (m_watch < 0) begin
         if (s != 4'hF) begin
            m_watch = m_row * 4 + lowest_low(s);
            m_low   = 1;
         end else begin
            m_row = (m_row + 1) % 4;
         end
      end else begin
         cb = s[m_watch % 4];
         if (!m_held) begin
            if (!cb) begin
               m_low++;
               if (m_low >= DB) begin
                  m_code = m_watch; m_valid = 1; m_held = 1; m_high = 0;
               end
            end else begin
               m_row = (m_watch / 4 + 1) % 4;
               m_watch = -1;
            end
         end else begin
            if (cb) begin
               m_high++;
               if (m_high >= DB) begin
                  m_held = 0;
                  m_row = (m_watch / 4 + 1) % 4;
                  m_watch = -1;
               end
            end else begin
               m_high = 0;
            end
         end
      end
   endtask

   // One clock: sample settled col, advance model on the edge, compare at negedge.
   task automatic step();
      logic [3:0] c_now;
      logic [3:0] er;
      #1;
      c_now = col;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(c_now);
      @(negedge clk);
      er = 4'b1111;
      er[m_row] = 1'b0;
      check("row", row, er);
      check("key_code", key_code, m_code[3:0]);
      check("key_valid", key_valid, m_valid);
      check("key_held", key_held, m_held);
      if (key_valid) n_valid_seen++;
   endtask

   task automatic wait_held(input logic lvl, input int bound, input string tag);
      int k;
      k = 0;
      while (key_held !== lvl && k < bound) begin
         step();
         k++;
      end
      check(tag, key_held, lvl);
   endtask

   logic [3:0] rot_tab [4];

   initial begin
      int k;
      int nk;
      int dur;
      n_checks = 0; n_fail = 0; n_valid_seen = 0;
      pressed = '0;
      rot_tab = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      model_reset();

      // Reset without a clock
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_row", row, 4'b1110);
      check("rst_code", key_code, 4'h0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_held", key_held, 1'b0);
      clk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle rotation
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i % 4 == 0) check("rotate", row, rot_tab[i/4-1]);
      end

      // Clean press of (2,1)
      n_valid_seen = 0;
      pressed = 16'h0200;
      wait_held(1'b1, 80, "t2_press");
      check("t2_code", key_code, 4'h9);
      check("t2_row", row, 4'b1011);
      repeat (20 * SCAN_DIV) step();
      check("t2_valid_once", n_valid_seen, 1);
      pressed = '0;
      wait_held(1'b0, 40, "t2_release");
      check("t2_row_after", row, 4'b0111);

      // Bounce on (0,3): two low ticks from the start of a row-0 period
      k = 0;
      while (!(m_watch < 0 && m_row == 0 && m_tick == 0) && k < 40) begin
         step();
         k++;
      end
      check("t3_align", row, 4'b1110);
      n_valid_seen = 0;
      pressed = 16'h0008;
      repeat (2 * SCAN_DIV) step();
      pressed = '0;
      repeat (SCAN_DIV) step();
      check("t3_row", row, 4'b1101);
      check("t3_valid", n_valid_seen, 0);
      check("t3_held", key_held, 1'b0);
      check("t3_code", key_code, 4'h9);

      // Release glitch on (1,0)
      n_valid_seen = 0;
      pressed = 16'h0010;
      wait_held(1'b1, 80, "t4_press");
      k = 0;
      while (m_tick != 0 && k < 8) begin
         step();
         k++;
      end
      pressed = '0;
      repeat (SCAN_DIV) step();
      pressed = 16'h0010;
      repeat (2 * SCAN_DIV) step();
      check("t4_held_mid", key_held, 1'b1);
      pressed = '0;
      repeat (3 * SCAN_DIV - 1) step();
      check("t4_held_before", key_held, 1'b1);
      step();
      check("t4_held_exit", key_held, 1'b0);
      check("t4_valid_once", n_valid_seen, 1);

      // Simultaneous keys on row 3, then an ignored key on row 0
      n_valid_seen = 0;
      pressed = 16'h9000;
      wait_held(1'b1, 80, "t5_press");
      check("t5_code", key_code, 4'hC);
      pressed = 16'h9004;
      repeat (3 * SCAN_DIV) step();
      check("t5_valid_once", n_valid_seen, 1);
      check("t5_code_keep", key_code, 4'hC);
      pressed = '0;
      wait_held(1'b0, 40, "t5_release");
      pressed = 16'h0004;
      wait_held(1'b1, 80, "t5_press2");
      check("t5_code2", key_code, 4'h2);
      pressed = '0;
      wait_held(1'b0, 40, "t5_release2");

      // Reset in the middle of debouncing (1,2)
      pressed = 16'h0040;
      k = 0;
      while (!(m_watch == 6 && m_low == 2) && k < 80) begin
         step();
         k++;
      end
      check("t6_reach_cnt2", m_watch == 6 && m_low == 2, 1'b1);
      n_valid_seen = 0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_row", row, 4'b1110);
      check("t6_rst_code", key_code, 4'h0);
      check("t6_rst_valid", key_valid, 1'b0);
      check("t6_rst_held", key_held, 1'b0);
      model_reset();
      @(negedge clk);
      repeat (2) step();
      rst_n = 1'b1;
      wait_held(1'b1, 80, "t6_press");
      check("t6_code", key_code, 4'h6);
      check("t6_valid_once", n_valid_seen, 1);
      pressed = '0;
      wait_held(1'b0, 40, "t6_release");

      // Randomized key patterns and hold times
      for (int n = 0; n < 40; n++) begin
         nk = $urandom_range(0, 2);
         pressed = '0;
         for (int b = 0; b < nk; b++) pressed[$urandom_range(0, 15)] = 1'b1;
         dur = $urandom_range(1, 40);
         repeat (dur) step();
      end
      pressed = '0;
      repeat (60) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
